// File: rtl/psum_glb_ctrl.sv
// psum_glb_ctrl: psum global-buffer sequencer; pipelined saturating accumulate
// with same-address forwarding, and a valid/ready range drain through a 2-entry skid buffer.
module psum_glb_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 193600,
    parameter int ADDR       = $clog2(DEPTH)
) (
    input  logic                  i_core_clk,
    input  logic                  i_reset,
    input  logic                  i_acc_en,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [ADDR-1:0]       i_in_addr,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    input  logic                  i_in_first,
    input  logic                  i_drain_start,
    input  logic [ADDR-1:0]       i_drain_base,
    input  logic [ADDR-1:0]       i_drain_count,
    output logic                  o_drain_done,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic                  o_glb_we_a,
    output logic [ADDR-1:0]       o_glb_addr_a,
    output logic [DATA_WIDTH-1:0] o_glb_wdata_a,
    output logic                  o_glb_re_b,
    output logic [ADDR-1:0]       o_glb_addr_b,
    input  logic [DATA_WIDTH-1:0] i_glb_rdata_b,
    output logic                  o_busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [DATA_WIDTH-1:0] W_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    logic [1:0]            r_state, w_state_n;
    logic                  r_pend;
    logic                  r_s1_v, r_s1_first, r_s1_fwd;
    logic [ADDR-1:0]       r_s1_addr;
    logic [DATA_WIDTH-1:0] r_s1_data, r_last;
    logic [ADDR-1:0]       r_rd_addr, r_rd_rem, r_out_rem;
    logic                  r_inf;
    logic [1:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_sk0, r_sk1;

    logic                  w_in_ready, w_acc, w_acc_re, w_dr_re, w_pop, w_last_pop, w_load;
    logic [1:0]            w_occ, w_c1;
    logic [DATA_WIDTH-1:0] w_old, w_sat, w_sum;
    logic [DATA_WIDTH:0]   w_ext;

    assign w_in_ready = !i_reset && r_state == S_ACCUM && !r_pend;
    assign w_acc      = i_in_valid && w_in_ready;
    assign w_acc_re   = w_acc && !i_in_first;
    assign w_pop      = r_cnt != 2'd0 && i_out_ready;
    assign w_last_pop = w_pop && r_out_rem == ADDR'(1);
    assign w_c1       = r_cnt - {1'b0, w_pop};
    // occupancy counts the slot freed by this cycle's pop so a full-rate stream never bubbles
    assign w_occ      = {1'b0, r_inf} + w_c1;
    assign w_dr_re    = r_state == S_DRAIN && r_rd_rem != '0 && w_occ < 2'd2;
    assign w_load     = i_drain_start && (r_state == S_IDLE || (r_state == S_ACCUM && !r_pend));

    assign w_old = r_s1_fwd ? r_last : i_glb_rdata_b;
    assign w_ext = {w_old[DATA_WIDTH-1], w_old} + {r_s1_data[DATA_WIDTH-1], r_s1_data};
    assign w_sat = (w_ext[DATA_WIDTH] != w_ext[DATA_WIDTH-1]) ? (w_ext[DATA_WIDTH] ? ~W_MAX : W_MAX)
                                                              : w_ext[DATA_WIDTH-1:0];
    assign w_sum = r_s1_first ? r_s1_data : w_sat;

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE:  w_state_n = i_drain_start ? S_DRAIN : (i_acc_en && !r_pend) ? S_ACCUM : S_IDLE;
            S_ACCUM: w_state_n = (r_pend && !r_s1_v) ? S_DRAIN :
                                 (!i_acc_en && !r_pend && !i_drain_start && !r_s1_v && !w_acc) ? S_IDLE : S_ACCUM;
            S_DRAIN: w_state_n = (r_out_rem == '0 || w_last_pop) ? S_DONE : S_DRAIN;
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_core_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_pend     <= 1'b0;
            r_s1_v     <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_fwd   <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_data  <= '0;
            r_last     <= '0;
            r_rd_addr  <= '0;
            r_rd_rem   <= '0;
            r_out_rem  <= '0;
            r_inf      <= 1'b0;
            r_cnt      <= 2'd0;
            r_sk0      <= '0;
            r_sk1      <= '0;
        end else begin
            r_state <= w_state_n;
            r_pend  <= r_state == S_ACCUM && w_state_n == S_ACCUM && (r_pend || i_drain_start);
            r_s1_v  <= w_acc;
            if (w_acc) begin
                r_s1_addr  <= i_in_addr;
                r_s1_data  <= i_in_data;
                r_s1_first <= i_in_first;
                r_s1_fwd   <= r_s1_v && r_s1_addr == i_in_addr;
            end
            if (r_s1_v)
                r_last <= w_sum;
            if (w_load) begin
                r_rd_addr <= i_drain_base;
                r_rd_rem  <= i_drain_count;
                r_out_rem <= i_drain_count;
            end else begin
                if (w_dr_re) begin
                    r_rd_addr <= r_rd_addr + ADDR'(1);
                    r_rd_rem  <= r_rd_rem - ADDR'(1);
                end
                if (w_pop)
                    r_out_rem <= r_out_rem - ADDR'(1);
            end
            r_inf <= w_dr_re;
            r_cnt <= w_c1 + {1'b0, r_inf};
            r_sk0 <= (r_inf && w_c1 == 2'd0) ? i_glb_rdata_b : w_pop ? r_sk1 : r_sk0;
            r_sk1 <= (r_inf && w_c1 == 2'd1) ? i_glb_rdata_b : r_sk1;
        end
    end

    assign o_in_ready    = w_in_ready;
    assign o_glb_re_b    = w_acc_re || w_dr_re;
    assign o_glb_addr_b  = w_acc_re ? i_in_addr : w_dr_re ? r_rd_addr : '0;
    assign o_glb_we_a    = r_s1_v;
    assign o_glb_addr_a  = r_s1_addr;
    assign o_glb_wdata_a = r_s1_v ? w_sum : '0;
    assign o_out_valid   = r_cnt != 2'd0;
    assign o_out_data    = r_sk0;
    assign o_drain_done  = r_state == S_DONE;
    assign o_busy        = r_state != S_IDLE || r_s1_v || r_inf || r_cnt != 2'd0;
endmodule

// File: tb/tb_psum_glb_ctrl.sv
// tb_psum_glb_ctrl: directed vector bench for psum_glb_ctrl with a behavioural
// 1-cycle-latency buffer model attached to ports A/B.
module tb_psum_glb_ctrl;
    localparam int DW = 16;
    localparam int DEPTH = 1024;
    localparam int AW = $clog2(DEPTH);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, acc_en, in_valid, in_ready, in_first;
    logic [AW-1:0] in_addr, drain_base, drain_count, waddr, raddr;
    logic [DW-1:0] in_data, out_data, wdata, rdata;
    logic          drain_start, drain_done, out_valid, out_ready, we, re, busy;

    psum_glb_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .i_core_clk(clk), .i_reset(rst), .i_acc_en(acc_en),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_addr(in_addr),
        .i_in_data(in_data), .i_in_first(in_first),
        .i_drain_start(drain_start), .i_drain_base(drain_base), .i_drain_count(drain_count),
        .o_drain_done(drain_done), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_data(out_data), .o_glb_we_a(we), .o_glb_addr_a(waddr), .o_glb_wdata_a(wdata),
        .o_glb_re_b(re), .o_glb_addr_b(raddr), .i_glb_rdata_b(rdata), .o_busy(busy)
    );

    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

    int errs = 0, checks = 0;
    logic [DW-1:0] dexp [0:15];

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          first;
        logic [DW-1:0] wexp;
    } vec_t;
    vec_t tv [0:13];

    function automatic vec_t mk(input int a, input int d, input int f, input int w);
        vec_t v;
        v.addr = AW'(a); v.data = DW'(d); v.first = f[0]; v.wexp = DW'(w);
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        #1;
        while (!in_ready && n < 50) begin @(negedge clk); #1; n++; end
        chk("wait_in_ready", int'(in_ready), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        #1;
        while (busy && n < 50) begin @(negedge clk); #1; n++; end
        chk("wait_idle", int'(busy), 0);
    endtask

    // mode 0: out_ready held high; mode 1: out_ready 1,0,0 repeating
    task automatic run_drain(input int base, input int cnt, input int mode, input string nm, input bit pulse);
        int got = 0, reads = 0, bad = 0, hs_first = -1, hs_last = -1, done_k = -1;
        bit stalled = 0;
        logic [DW-1:0] held = '0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            drain_start = pulse && k == 0;
            drain_base  = AW'(base);
            drain_count = AW'(cnt);
            out_ready   = mode == 0 ? 1'b1 : (k % 3 == 0);
            #1;
            if (re) begin
                if (raddr != AW'(base + reads) || we) bad++;
                reads++;
            end
            if (out_valid) begin
                if (stalled && out_data != held) bad++;
                if (out_ready) begin
                    if (got >= cnt || out_data != dexp[got]) bad++;
                    got++;
                    if (hs_first < 0) hs_first = k;
                    hs_last = k;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = out_data;
                end
            end
            if (drain_done) begin done_k = k; break; end
        end
        chk({nm, "_words"}, got, cnt);
        chk({nm, "_reads"}, reads, cnt);
        chk({nm, "_order_stable"}, bad, 0);
        chk({nm, "_done_seen"}, int'(done_k >= 0), 1);
        if (cnt > 0) chk({nm, "_done_latency"}, done_k, hs_last + 1);
        if (mode == 0 && cnt > 0) chk({nm, "_rate"}, hs_last - hs_first + 1, cnt);
        @(negedge clk);
        drain_start = 0;
        #1;
        chk({nm, "_done_pulse"}, int'(drain_done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int bad_w, bad_r, hs;
        logic [DW-1:0] sexp [0:127];
        tv[0]  = mk(5,  'h1234, 1, 'h1234);
        tv[1]  = mk(7,  'h0000, 1, 'h0000);
        tv[2]  = mk(5,  100,    1, 100);
        tv[3]  = mk(5,  20,     0, 120);
        tv[4]  = mk(9,  'h7FF0, 1, 'h7FF0);
        tv[5]  = mk(11, 'h8010, 1, 'h8010);
        tv[6]  = mk(9,  'h0020, 0, 'h7FFF);
        tv[7]  = mk(11, 'hFFD0, 0, 'h8000);
        tv[8]  = mk(11, 'h0005, 0, 'h8005);
        tv[9]  = mk(9,  'hFFFF, 0, 'h7FFE);
        tv[10] = mk(5,  'hFFF6, 0, 'h006E);
        tv[11] = mk(12, 'h8000, 1, 'h8000);
        tv[12] = mk(12, 'h8000, 0, 'h8000);
        tv[13] = mk(12, 'h7FFF, 0, 'hFFFF);

        rst = 1; acc_en = 1; in_valid = 1; in_first = 1; in_addr = '0; in_data = '0;
        drain_start = 1; drain_base = '0; drain_count = AW'(4); out_ready = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_we", int'(we), 0);
        chk("rst_re", int'(re), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_drain_done", int'(drain_done), 0);
        chk("rst_wdata", int'(wdata), 0);
        chk("rst_waddr", int'(waddr), 0);
        chk("rst_out_data", int'(out_data), 0);
        @(negedge clk);
        rst = 0; in_valid = 0; drain_start = 0; acc_en = 0;
        #1;
        chk("post_rst_busy", int'(busy), 0);

        // accumulate vectors: forwarding and saturation
        @(negedge clk);
        acc_en = 1;
        wait_ready();
        for (int i = 0; i <= 14; i++) begin
            @(negedge clk);
            in_valid = i < 14;
            if (i < 14) begin
                in_addr = tv[i].addr; in_data = tv[i].data; in_first = tv[i].first;
            end
            #1;
            if (i < 14) begin
                chk($sformatf("tv%0d_ready", i), int'(in_ready), 1);
                chk($sformatf("tv%0d_re", i), int'(re), int'(!tv[i].first));
                if (!tv[i].first) chk($sformatf("tv%0d_raddr", i), int'(raddr), int'(tv[i].addr));
            end
            if (i > 0) begin
                chk($sformatf("tv%0d_we", i - 1), int'(we), 1);
                chk($sformatf("tv%0d_waddr", i - 1), int'(waddr), int'(tv[i - 1].addr));
                chk($sformatf("tv%0d_wdata", i - 1), int'(wdata), int'(tv[i - 1].wexp));
            end
        end

        // 64 overwrites then 64 increments, streamed back-to-back
        for (int i = 0; i < 64; i++) begin
            sexp[i] = DW'(i * 7);
            sexp[64 + i] = DW'(i * 7 + 1);
        end
        bad_w = 0; bad_r = 0;
        for (int k = 0; k <= 128; k++) begin
            @(negedge clk);
            in_valid = k < 128;
            in_addr  = AW'(k % 64);
            in_data  = k < 64 ? DW'(k * 7) : DW'(1);
            in_first = k < 64;
            #1;
            if (k < 128 && !in_ready) bad_r++;
            if (k > 0 && (!we || waddr != AW'((k - 1) % 64) || wdata != sexp[k - 1])) bad_w++;
        end
        chk("stream_writes", bad_w, 0);
        chk("stream_ready", bad_r, 0);
        in_valid = 0; acc_en = 0;
        wait_idle();

        for (int i = 0; i < 8; i++) dexp[i] = DW'((10 + i) * 7 + 1);
        run_drain(10, 8, 1, "drain_toggle", 1);
        chk("drain_toggle_idle", int'(busy), 0);
        for (int i = 0; i < 6; i++) dexp[i] = DW'((30 + i) * 7 + 1);
        run_drain(30, 6, 0, "drain_full", 1);
        run_drain(3, 0, 0, "drain_zero", 1);
        chk("drain_zero_idle", int'(busy), 0);

        // drain requested in the middle of a forwarding accumulate stream
        @(negedge clk);
        acc_en = 1;
        wait_ready();
        bad_r = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            in_valid = 1; in_addr = AW'(40); in_data = DW'(1); in_first = 0;
            drain_start = j == 5; drain_base = AW'(38); drain_count = AW'(4);
            #1;
            if (!in_ready) bad_r++;
        end
        chk("pend_stream_ready", bad_r, 0);
        @(negedge clk);
        drain_start = 0;
        #1;
        chk("pend_in_ready_drop", int'(in_ready), 0);
        chk("pend_last_we", int'(we), 1);
        chk("pend_last_wdata", int'(wdata), 287);
        in_valid = 0;
        dexp[0] = DW'(267); dexp[1] = DW'(274); dexp[2] = DW'(287); dexp[3] = DW'(288);
        run_drain(38, 4, 0, "drain_pend", 0);
        acc_en = 0;
        wait_idle();

        // reset with three words still owed
        for (int i = 0; i < 8; i++) dexp[i] = DW'(i * 7 + 1);
        @(negedge clk);
        drain_start = 1; drain_base = '0; drain_count = AW'(8); out_ready = 1;
        hs = 0;
        for (int k = 0; k < 50 && hs < 5; k++) begin
            @(negedge clk);
            drain_start = 0;
            #1;
            if (out_valid && out_ready) hs++;
        end
        chk("rst_mid_hs", hs, 5);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        #1;
        chk("rst_mid_out_valid", int'(out_valid), 0);
        chk("rst_mid_re", int'(re), 0);
        chk("rst_mid_we", int'(we), 0);
        chk("rst_mid_busy", int'(busy), 0);
        rst = 0;
        for (int i = 0; i < 5; i++) dexp[i] = DW'((20 + i) * 7 + 1);
        run_drain(20, 5, 1, "drain_after_rst", 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/psum_glb_ctrl.md
Name: psum_glb_ctrl

Overview:
- Sequences the banked psum global buffer: owns its write port A and read port B.
- Accumulate mode: takes the PE-array psum stream (address, value, first flag) and performs a pipelined read-modify-write, one psum per cycle, with forwarding for back-to-back hits on the same address.
- Drain mode: reads a contiguous address range from the buffer and streams it out over a valid/ready interface to the ofmap/output path.

Parameters:
- DATA_WIDTH, 16, psum word width (signed two's complement)
- DEPTH, 193600, buffer depth in words
- ADDR, $clog2(DEPTH), address width

Ports:
- core_clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- acc_en  in  1  level; 1 = accumulate mode enabled
- in_valid  in  1  psum request valid
- in_ready  out  1  controller accepts psum this cycle
- in_addr  in  ADDR  psum target address
- in_data  in  DATA_WIDTH  psum value
- in_first  in  1  1 = overwrite, no read-back
- drain_start  in  1  one-cycle pulse, starts a drain
- drain_base  in  ADDR  first drain address, sampled on drain_start
- drain_count  in  ADDR  number of words to drain, sampled on drain_start
- drain_done  out  1  one-cycle pulse after the last word is handshaken out
- out_valid  out  1  drained word valid
- out_ready  in  1  downstream accepts the drained word
- out_data  out  DATA_WIDTH  drained word
- glb_we_a  out  1  buffer write enable
- glb_addr_a  out  ADDR  buffer write address
- glb_wdata_a  out  DATA_WIDTH  buffer write data
- glb_re_b  out  1  buffer read enable
- glb_addr_b  out  ADDR  buffer read address
- glb_rdata_b  in  DATA_WIDTH  buffer read data; valid the cycle after glb_re_b
- busy  out  1  FSM not in IDLE, or pipeline not empty

Behaviour:
- Reset: FSM = IDLE. All pipeline valids, glb_we_a, glb_re_b, out_valid, drain_done, busy and in_ready = 0. All data/address outputs = 0.
- FSM states and transitions:
  - IDLE: go to ACCUM when acc_en=1 and no drain is pending; go to DRAIN on drain_start.
  - ACCUM -> IDLE: when acc_en=0 and the pipeline is empty.
  - DRAIN -> DONE: when all drain_count words have been handshaken out.
  - DONE: single cycle, asserts drain_done, -> IDLE.
  - drain_start in ACCUM: latched as pending. in_ready drops the next cycle; the pipeline flushes; then the FSM enters DRAIN.
- in_ready = (state==ACCUM) and no pending drain.
- Accumulate pipeline, 2 stages, throughput 1/cycle:
  - S0 (accept cycle): if in_first=0, drive glb_re_b=1 and glb_addr_b=in_addr. If in_first=1, no read.
  - S0 hazard check: if S1 holds a valid op with the same address, set a fwd flag.
  - S1 (next cycle): old = fwd ? last_wdata : glb_rdata_b.
  - S1 sum = sat(old + data); if first, sum = data.
  - S1 drives glb_we_a=1, glb_addr_a, glb_wdata_a=sum. The written value is registered as last_wdata.
  - Write latency: 1 cycle after acceptance.
- Arithmetic: signed DATA_WIDTH addition, saturating. Positive overflow -> 0x7FFF; negative overflow -> 0x8000 (DATA_WIDTH=16).
- Simultaneous read and write to the same address never relies on RAM read-during-write behaviour; forwarding covers it.
- Drain datapath:
  - Read address counter starts at drain_base.
  - glb_re_b issued when reads remaining > 0 and (words in flight + words in the 2-entry output skid buffer) < 2.
  - Read data is captured into the skid buffer the cycle after issue.
  - out_valid/out_data come from the skid buffer head; pop on out_valid & out_ready.
  - out_data is held stable while out_valid=1 and out_ready=0.
  - Words leave in address order; no drops and no duplicates under any out_ready pattern.
  - Sustains 1 word/cycle when out_ready stays high.
- drain_count=0: DRAIN -> DONE immediately, no reads issued, drain_done pulses.
- Addresses do not wrap. base+count > DEPTH is illegal; behaviour undefined.
- Reset mid-operation: all in-flight ops and skid contents are discarded. No glb_we_a in the cycle after reset asserts. Partial buffer contents are left as-is.
- in_valid or drain_start while in reset: ignored.

Test Plan:
1. Reset, acc_en=1, send (addr 5, 100, first=1) then (addr 5, 20, first=0) back-to-back -> addr 5 written 100 then 120. Second op uses forwarding, and its glb_rdata_b is ignored.
2. Preload addr 9 = 0x7FF0, send (9, 0x0020, first=0) -> written 0x7FFF. Preload 0x8010, add 0xFFD0 -> written 0x8000.
3. 64 psums to addresses 0..63 with first=1, then 64 with value 1 and first=0 -> each address = original+1. One glb_we_a per cycle, in_ready steady 1.
4. drain_start base=10, count=8, out_ready toggling 1,0,0,1,... -> out_data = mem[10..17] in order, exactly 8 handshakes, drain_done one cycle after the last, then IDLE.
5. drain_start during a continuous accumulate stream -> in_ready falls the next cycle, the last accepted write completes before the first drain read, drained data includes that write.
6. reset asserted mid-drain with 3 words outstanding -> next cycle out_valid=0, glb_re_b=0, state IDLE. A new drain after reset returns correct data.
